// File: rtl/ppc_mem_pkg.sv
// ----------------------------------------------------------------------------
// ppc_mem_pkg
// Shared widths and enumerations for the PPC memory-port arbiter slice.
//   MEM_ADDR_W  : doubleword address width driven to the memory read port
//   MEM_DATA_W  : read data width returned by the memory
//   CNT_W       : width of the latency and LD-streak counters (values 0..15)
//   owner_t     : which requester currently owns (or last won) the port
//   arb_state_t : arbiter sequencing state
// PPC numbering puts bit 0 at the MSB. Vectors here are declared [W-1:0], so
// PPC bit 0 is index W-1.
// ----------------------------------------------------------------------------
package ppc_mem_pkg;

    localparam int MEM_ADDR_W = 61;
    localparam int MEM_DATA_W = 64;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LD
    } owner_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/ppc_mem_arb_pick.sv
// ----------------------------------------------------------------------------
// ppc_mem_arb_pick
// Combinational winner selection between instruction fetch (IF) and the load
// unit (LD). Only consulted while the arbiter is idle.
//   Build option PPC_MEM_ARB_RR_EN:
//     undefined : LD beats IF, except IF wins once streak == MAX_LD_STREAK
//     defined   : round robin; on contention the requester not in `last` wins
// Ports:
//   if_req, ld_req : request lines
//   streak         : consecutive LD grants taken while IF was waiting
//   last           : owner of the most recent grant
//   winner         : selected requester, OWN_NONE when nothing is requested
// ----------------------------------------------------------------------------
module ppc_mem_arb_pick
    import ppc_mem_pkg::*;
#(
    parameter int unsigned MAX_LD_STREAK = 4
) (
    input  logic             if_req,
    input  logic             ld_req,
    input  logic [CNT_W-1:0] streak,
    input  owner_t           last,
    output owner_t           winner
);

`ifdef PPC_MEM_ARB_RR_EN
    // The streak input and its limit only matter for fixed priority.
    logic unused_streak;
    assign unused_streak = ^{streak, CNT_W'(MAX_LD_STREAK)};

    always_comb begin
        winner = OWN_NONE;
        if (if_req && ld_req) begin
            winner = (last == OWN_LD) ? OWN_IF : OWN_LD;
        end else if (if_req) begin
            winner = OWN_IF;
        end else if (ld_req) begin
            winner = OWN_LD;
        end
    end
`else
    // Grant history only matters for round robin.
    logic unused_last;
    assign unused_last = ^last;

    // NOTE: winner gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        winner = OWN_NONE;
        if (if_req && ld_req) begin
            // IF has sat out MAX_LD_STREAK back-to-back LD grants: force it in.
            winner = (streak == CNT_W'(MAX_LD_STREAK)) ? OWN_IF : OWN_LD;
        end else if (if_req) begin
            winner = OWN_IF;
        end else if (ld_req) begin
            winner = OWN_LD;
        end
    end
`endif

endmodule

// File: rtl/ppc_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// ppc_mem_port_arbiter
// Shares one memory read port between instruction fetch (IF) and the load
// unit (LD). An access is granted from IDLE, held in BUSY for LATENCY cycles
// with mem_addr stable, then the data is captured for the owner and a one-cycle
// valid is raised. At most one access is outstanding.
// Build option PPC_MEM_ARB_RR_EN selects round-robin arbitration (see
// ppc_mem_arb_pick); timing and handshake do not change.
// Parameters:
//   LATENCY       : cycles from grant edge to data capture edge (1..15)
//   MAX_LD_STREAK : LD grants allowed while IF waits before IF is forced (1..15)
// Ports:
//   clk, reset                : clock; asynchronous active-high reset
//   if_req/if_addr            : IF request, held until if_valid
//   if_gnt/if_valid/if_data   : IF accept pulse, result pulse, result data
//   ld_req/ld_addr            : LD request, held until ld_valid
//   ld_gnt/ld_valid/ld_data   : LD accept pulse, result pulse, result data
//   mem_addr/mem_data         : memory read address and combinational data
// ----------------------------------------------------------------------------
module ppc_mem_port_arbiter
    import ppc_mem_pkg::*;
#(
    parameter int unsigned LATENCY       = 2,
    parameter int unsigned MAX_LD_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [MEM_ADDR_W-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [MEM_DATA_W-1:0] if_data,
    input  logic                  ld_req,
    input  logic [MEM_ADDR_W-1:0] ld_addr,
    output logic                  ld_gnt,
    output logic                  ld_valid,
    output logic [MEM_DATA_W-1:0] ld_data,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [MEM_DATA_W-1:0] mem_data
);

    arb_state_t       state;
    arb_state_t       state_next;
    owner_t           owner;
    owner_t           last;
    owner_t           winner;
    owner_t           grant;
    logic             capture;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] streak;
    logic [CNT_W-1:0] streak_next;

    ppc_mem_arb_pick #(
        .MAX_LD_STREAK (MAX_LD_STREAK)
    ) u_pick (
        .if_req (if_req),
        .ld_req (ld_req),
        .streak (streak),
        .last   (last),
        .winner (winner)
    );

    // Next state, grant decision and capture strobe.
    always_comb begin
        state_next  = state;
        grant       = OWN_NONE;
        capture     = 1'b0;
        streak_next = '0;
        case (state)
            ARB_IDLE: begin
                if (if_req || ld_req) begin
                    grant      = winner;
                    state_next = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
        // The streak only grows while IF is actually being passed over; any IF
        // grant, or an uncontended LD grant, restarts it.
        if (grant == OWN_LD && if_req) begin
            streak_next = (streak == CNT_W'(MAX_LD_STREAK)) ? streak : streak + CNT_W'(1);
        end
    end

    // NOTE: every register here uses non-blocking assignment so each one sees
    // the pre-edge value of the others, independent of statement order.
    // Data registers are reset too, so a discarded access leaves no stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            owner    <= OWN_NONE;
            last     <= OWN_IF;
            cnt      <= '0;
            streak   <= '0;
            mem_addr <= '0;
            if_data  <= '0;
            ld_data  <= '0;
            if_gnt   <= 1'b0;
            ld_gnt   <= 1'b0;
            if_valid <= 1'b0;
            ld_valid <= 1'b0;
        end else begin
            state    <= state_next;
            if_gnt   <= (grant == OWN_IF);
            ld_gnt   <= (grant == OWN_LD);
            if_valid <= capture && (owner == OWN_IF);
            ld_valid <= capture && (owner == OWN_LD);
            if (grant != OWN_NONE) begin
                owner    <= grant;
                last     <= grant;
                mem_addr <= (grant == OWN_LD) ? ld_addr : if_addr;
                cnt      <= CNT_W'(LATENCY - 1);
                streak   <= streak_next;
            end else if (capture) begin
                owner <= OWN_NONE;
                if (owner == OWN_IF) begin
                    if_data <= mem_data;
                end
                if (owner == OWN_LD) begin
                    ld_data <= mem_data;
                end
            end else if (state == ARB_BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ppc_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ppc_mem_port_arbiter
// Two arbiters side by side: u0 (LATENCY=2, MAX_LD_STREAK=4) and u1
// (LATENCY=1, MAX_LD_STREAK=2). Each requester is a queue of addresses: req is
// high while its queue is non-empty, and the head is popped in the valid cycle,
// so the next address is presented back-to-back. A transaction-level model
// (grant edge + LATENCY = capture edge) predicts every output on every cycle.
// Build option PPC_MEM_ARB_RR_EN switches the expected arbitration.
// ----------------------------------------------------------------------------
module tb_ppc_mem_port_arbiter;

`ifdef PPC_MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    localparam int LAT0  = 2;
    localparam int LAT1  = 1;
    localparam int MAXS0 = 4;
    localparam int MAXS1 = 2;

    logic             clk;
    logic             reset;
    logic [1:0]       if_req, ld_req;
    logic [1:0][60:0] if_addr, ld_addr;
    logic [1:0]       if_gnt, ld_gnt, if_valid, ld_valid;
    logic [1:0][63:0] if_data, ld_data, mem_data;
    logic [1:0][60:0] mem_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Requester queues and grant logs per instance.
    logic [60:0] qif [2][$];
    logic [60:0] qld [2][$];
    byte         gnt_log [2][$];
    int          ncyc = 0;
    int          if_gnt_cyc [2];
    int          ld_valid_cyc [2];

    // Model state and expectations.
    int               edge_no;
    bit   [1:0]       m_busy, m_own_ld, m_last_ld, win_ld;
    int               m_done [2];
    int               m_streak [2];
    logic [1:0][60:0] m_addr;
    logic [1:0]       e_if_gnt, e_ld_gnt, e_if_valid, e_ld_valid;
    logic [1:0][63:0] e_if_data, e_ld_data;
    logic [1:0][60:0] e_mem_addr;

    function automatic logic [63:0] mem_word(input logic [60:0] a);
        if (a == 61'h10) return 64'h7C221A14_38600041;
        return ({3'b000, a} * 64'h9E3779B9_7F4A7C15) ^ 64'h01234567_89ABCDEF;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int maxs_of(input int i);
        return (i == 0) ? MAXS0 : MAXS1;
    endfunction

    // Arbitration rule at the requester level: returns 1 when LD should win.
    function automatic bit pick_ld(input bit ifr, input bit ldr, input int streak,
                                   input int maxs, input bit last_ld);
        if (!ifr) return 1'b1;
        if (!ldr) return 1'b0;
        return RR_MODE ? !last_ld : (streak < maxs);
    endfunction

    assign mem_data[0] = mem_word(mem_addr[0]);
    assign mem_data[1] = mem_word(mem_addr[1]);

    ppc_mem_port_arbiter #(.LATENCY(LAT0), .MAX_LD_STREAK(MAXS0)) u0 (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_valid(if_valid[0]), .if_data(if_data[0]),
        .ld_req(ld_req[0]), .ld_addr(ld_addr[0]), .ld_gnt(ld_gnt[0]),
        .ld_valid(ld_valid[0]), .ld_data(ld_data[0]),
        .mem_addr(mem_addr[0]), .mem_data(mem_data[0])
    );

    ppc_mem_port_arbiter #(.LATENCY(LAT1), .MAX_LD_STREAK(MAXS1)) u1 (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_valid(if_valid[1]), .if_data(if_data[1]),
        .ld_req(ld_req[1]), .ld_addr(ld_addr[1]), .ld_gnt(ld_gnt[1]),
        .ld_valid(ld_valid[1]), .ld_data(ld_data[1]),
        .mem_addr(mem_addr[1]), .mem_data(mem_data[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always_comb begin
        win_ld = '0;
        for (int i = 0; i < 2; i++) begin
            win_ld[i] = pick_ld(if_req[i], ld_req[i], m_streak[i], maxs_of(i), m_last_ld[i]);
        end
    end

    // Transaction-level model: an access granted at edge n is captured at edge
    // n+LATENCY; the port is free again from the following edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_no <= 0;
            for (int i = 0; i < 2; i++) begin
                m_busy[i]     <= 1'b0;
                m_own_ld[i]   <= 1'b0;
                m_last_ld[i]  <= 1'b0;
                m_done[i]     <= 0;
                m_streak[i]   <= 0;
                m_addr[i]     <= '0;
                e_if_gnt[i]   <= 1'b0;
                e_ld_gnt[i]   <= 1'b0;
                e_if_valid[i] <= 1'b0;
                e_ld_valid[i] <= 1'b0;
                e_if_data[i]  <= '0;
                e_ld_data[i]  <= '0;
                e_mem_addr[i] <= '0;
            end
        end else begin
            edge_no <= edge_no + 1;
            for (int i = 0; i < 2; i++) begin
                e_if_gnt[i]   <= 1'b0;
                e_ld_gnt[i]   <= 1'b0;
                e_if_valid[i] <= 1'b0;
                e_ld_valid[i] <= 1'b0;
                if (m_busy[i]) begin
                    if (edge_no == m_done[i]) begin
                        m_busy[i] <= 1'b0;
                        if (m_own_ld[i]) begin
                            e_ld_valid[i] <= 1'b1;
                            e_ld_data[i]  <= mem_word(m_addr[i]);
                        end else begin
                            e_if_valid[i] <= 1'b1;
                            e_if_data[i]  <= mem_word(m_addr[i]);
                        end
                    end
                end else if (if_req[i] || ld_req[i]) begin
                    m_busy[i]     <= 1'b1;
                    m_done[i]     <= edge_no + lat_of(i);
                    m_own_ld[i]   <= win_ld[i];
                    m_last_ld[i]  <= win_ld[i];
                    m_addr[i]     <= win_ld[i] ? ld_addr[i] : if_addr[i];
                    e_mem_addr[i] <= win_ld[i] ? ld_addr[i] : if_addr[i];
                    if (win_ld[i]) begin
                        e_ld_gnt[i] <= 1'b1;
                        if (!if_req[i])
                            m_streak[i] <= 0;
                        else if (m_streak[i] < maxs_of(i))
                            m_streak[i] <= m_streak[i] + 1;
                    end else begin
                        e_if_gnt[i]  <= 1'b1;
                        m_streak[i] <= 0;
                    end
                end
            end
        end
    end

    // Compare every output of both instances on every falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d if_gnt", i),   64'(if_gnt[i]),   64'(e_if_gnt[i]));
            check($sformatf("u%0d ld_gnt", i),   64'(ld_gnt[i]),   64'(e_ld_gnt[i]));
            check($sformatf("u%0d if_valid", i), 64'(if_valid[i]), 64'(e_if_valid[i]));
            check($sformatf("u%0d ld_valid", i), 64'(ld_valid[i]), 64'(e_ld_valid[i]));
            check($sformatf("u%0d if_data", i),  if_data[i],       e_if_data[i]);
            check($sformatf("u%0d ld_data", i),  ld_data[i],       e_ld_data[i]);
            check($sformatf("u%0d mem_addr", i), 64'(mem_addr[i]), 64'(e_mem_addr[i]));
            if (if_gnt[i]) begin
                gnt_log[i].push_back("I");
                if_gnt_cyc[i] <= ncyc;
            end
            if (ld_gnt[i]) gnt_log[i].push_back("L");
            if (ld_valid[i]) ld_valid_cyc[i] <= ncyc;
        end
        ncyc <= ncyc + 1;
    end

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if_req[i]  = (qif[i].size() != 0);
            ld_req[i]  = (qld[i].size() != 0);
            if_addr[i] = (qif[i].size() != 0) ? qif[i][0] : '0;
            ld_addr[i] = (qld[i].size() != 0) ? qld[i][0] : '0;
        end
    endtask

    // Advance one cycle; the requester reacts to valid within the valid cycle.
    task automatic step();
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (if_valid[i] && qif[i].size() != 0) void'(qif[i].pop_front());
            if (ld_valid[i] && qld[i].size() != 0) void'(qld[i].pop_front());
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            qif[i].delete();
            qld[i].delete();
        end
        drive();
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) gnt_log[i].delete();
    endtask

    task automatic drain(input int i, input int budget);
        int n = 0;
        while ((qif[i].size() != 0 || qld[i].size() != 0) && n < budget) begin
            step();
            n++;
        end
        check($sformatf("u%0d drain within budget", i), 64'(n < budget), 64'd1);
        step();
        step();
    endtask

    task automatic check_order(input string name, input string exp_s);
        check({name, " count"}, 64'(gnt_log[0].size()), 64'(exp_s.len()));
        for (int k = 0; k < exp_s.len(); k++) begin
            check($sformatf("%s grant %0d", name, k),
                  64'((k < gnt_log[0].size()) ? gnt_log[0][k] : 8'h00), 64'(exp_s[k]));
        end
    endtask

    initial begin
        reset = 1'b1;
        drive();
        step();
        step();
        // Reset state.
        check("rst mem_addr", 64'(mem_addr[0]), 64'd0);
        check("rst if_data",  if_data[0], 64'd0);
        check("rst gnts",     64'({if_gnt, ld_gnt}), 64'd0);
        reset = 1'b0;
        step();

        // Single IF at LATENCY=2: gnt in cycle 1, valid in cycle 3.
        qif[0].push_back(61'h10);
        drive();
        step();
        check("if1 gnt",      64'(if_gnt[0]), 64'd1);
        check("if1 mem_addr", 64'(mem_addr[0]), 64'h10);
        step();
        check("if1 early valid", 64'(if_valid[0]), 64'd0);
        check("if1 mem_addr hold", 64'(mem_addr[0]), 64'h10);
        step();
        check("if1 valid",    64'(if_valid[0]), 64'd1);
        check("if1 data",     if_data[0], 64'h7C221A14_38600041);
        check("if1 mem_addr end", 64'(mem_addr[0]), 64'h10);
        check("model if_data pin", e_if_data[0], 64'h7C221A14_38600041);
        step();
        check("if1 no regrant", 64'(if_gnt[0]), 64'd0);

        // Starvation override (fixed) / alternation (RR) with IF held.
        do_reset();
        qif[0].push_back(61'h50);
        for (int k = 0; k < 6; k++) qld[0].push_back(61'h60 + 61'(k));
        drive();
        drain(0, 200);
        check_order("starve", RR_MODE ? "LILLLLL" : "LLLLILL");
        check("model streak pin", 64'(m_streak[0]), 64'd0);

        // Simultaneous requests: LD first, IF at the edge after ld_valid.
        do_reset();
        qif[0].push_back(61'h30);
        qld[0].push_back(61'h40);
        drive();
        drain(0, 100);
        check_order("simul", "LI");
        check("simul if after ld_valid", 64'(if_gnt_cyc[0] - ld_valid_cyc[0]), 64'd1);
        check("simul ld_data", ld_data[0], mem_word(61'h40));
        check("simul if_data", if_data[0], mem_word(61'h30));

        // Both continuously pending.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            qif[0].push_back(61'h80 + 61'(k));
            qld[0].push_back(61'h90 + 61'(k));
        end
        drive();
        drain(0, 200);
        check_order("contend", RR_MODE ? "LILILILI" : "LLLLIIII");

        // Back-to-back IF at LATENCY=1.
        qif[1].push_back(61'h20);
        qif[1].push_back(61'h21);
        drive();
        step();
        check("b2b gnt0",  64'(if_gnt[1]), 64'd1);
        check("b2b addr0", 64'(mem_addr[1]), 64'h20);
        step();
        check("b2b valid0", 64'(if_valid[1]), 64'd1);
        check("b2b data0",  if_data[1], mem_word(61'h20));
        step();
        check("b2b gnt1",  64'(if_gnt[1]), 64'd1);
        check("b2b addr1", 64'(mem_addr[1]), 64'h21);
        step();
        check("b2b valid1", 64'(if_valid[1]), 64'd1);
        check("b2b data1",  if_data[1], mem_word(61'h21));
        step();
        check("b2b idle", 64'({if_gnt[1], if_valid[1]}), 64'd0);

        // Reset in the middle of an LD access.
        do_reset();
        qld[0].push_back(61'h70);
        drive();
        step();
        check("mid ld_gnt", 64'(ld_gnt[0]), 64'd1);
        reset = 1'b1;
        qld[0].delete();
        drive();
        step();
        check("mid rst outputs", 64'({ld_gnt[0], ld_valid[0], if_gnt[0], if_valid[0]}), 64'd0);
        check("mid rst mem_addr", 64'(mem_addr[0]), 64'd0);
        check("mid rst ld_data", ld_data[0], 64'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) gnt_log[i].delete();
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("mid no ld_valid %0d", k), 64'(ld_valid[0]), 64'd0);
        end
        qif[0].push_back(61'h11);
        drive();
        drain(0, 100);
        check_order("post reset", "I");
        check("post reset if_data", if_data[0], mem_word(61'h11));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
